cwc_trace_reader: RTL and testbench

Readout engine for the ChipWatcher capture RAM: the reading end of the trace buffer that the capture hub writes.
- On command, it reads a contiguous (circularly wrapped) window of captured samples from the RAM read port.
- It serialises each sample little-endian into a byte stream with a valid/ready handshake.
- The stream feeds the host link (UART/JTAG bridge) and is prefixed by a fixed 4-byte header.

---
 rtl/cwc_trace_reader_if.sv | 10 +
 rtl/cwc_trace_reader.sv | 158 +++++++++++++++
 tb/tb_cwc_trace_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cwc_trace_reader_if.sv
// Byte stream from the trace reader to the host link bridge.
interface cwc_trace_reader_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/cwc_trace_reader.sv
// ChipWatcher capture-RAM readout: 4-byte header, then a circular window of
// samples serialised little-endian onto a valid/ready byte stream.
//
// state  | meaning
// IDLE   | waiting for dump_start
// HDR    | presenting A5 5A L[7:0] L[15:8]
// RD     | one-cycle RAM read of the current address
// WAIT   | RAM read latency, then load the shift register
// SEND   | presenting the NB bytes of the loaded sample
// DONE   | one-cycle done pulse, busy already low
module cwc_trace_reader #(
  parameter int SAMPLE_W = 67,
  parameter int ADDR_W   = 14,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dump_start,
  input  logic [ADDR_W-1:0]   dump_base,
  input  logic [ADDR_W:0]     dump_len,
  input  logic                dump_abort,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [SAMPLE_W-1:0] ram_rd_data,
  cwc_trace_reader_if.master  m_axis,
  output logic                busy,
  output logic                done
);

  localparam int NB   = (SAMPLE_W + 7) / 8;
  localparam int SH_W = NB * 8;
  localparam int BI_W = (NB > 4) ? $clog2(NB) : 2;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   remaining;
  logic [BI_W-1:0]   byte_idx;
  logic [1:0]        wait_cnt;
  logic [SH_W-1:0]   shift_q;
  logic [15:0]       hdr_len;
  logic              hdr_last, last_byte, final_sample, len_zero;

  // remaining is untouched until the first sample completes, so it doubles as L
  assign hdr_len      = 16'(remaining);
  assign hdr_last     = (byte_idx[1:0] == 2'd3);
  assign last_byte    = (byte_idx == LAST_BYTE);
  assign final_sample = (remaining == (ADDR_W+1)'(1));
  assign len_zero     = (remaining == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    m_axis.m_tvalid = 1'b0;
    m_axis.m_tdata  = 8'h00;
    m_axis.m_tlast  = 1'b0;
    ram_rd_en       = 1'b0;
    ram_rd_addr     = rd_addr_q;
    busy            = 1'b1;
    done            = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (dump_start) state_d = S_HDR;
      end
      S_HDR: begin
        m_axis.m_tvalid = 1'b1;
        case (byte_idx[1:0])
          2'd0:    m_axis.m_tdata = 8'hA5;
          2'd1:    m_axis.m_tdata = 8'h5A;
          2'd2:    m_axis.m_tdata = hdr_len[7:0];
          default: m_axis.m_tdata = hdr_len[15:8];
        endcase
        m_axis.m_tlast = hdr_last && len_zero;
        if (dump_abort)                        state_d = S_IDLE;
        else if (m_axis.m_tready && hdr_last)  state_d = len_zero ? S_DONE : S_RD;
      end
      S_RD: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = cur_addr;
        state_d     = dump_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (dump_abort)          state_d = S_IDLE;
        else if (wait_cnt == '0) state_d = S_SEND;
      end
      S_SEND: begin
        m_axis.m_tvalid = 1'b1;
        m_axis.m_tdata  = shift_q[7:0];
        m_axis.m_tlast  = last_byte && final_sample;
        if (dump_abort)                         state_d = S_IDLE;
        else if (m_axis.m_tready && last_byte)  state_d = final_sample ? S_DONE : S_RD;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      rd_addr_q <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (dump_start) begin
          cur_addr  <= dump_base;
          remaining <= dump_len;
          byte_idx  <= '0;
        end
        S_HDR: if (m_axis.m_tready) byte_idx <= hdr_last ? '0 : byte_idx + BI_W'(1);
        S_RD: begin
          rd_addr_q <= cur_addr;
          wait_cnt  <= 2'(RD_LAT - 1);
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            shift_q  <= SH_W'(ram_rd_data);
            byte_idx <= '0;
          end
        end
        S_SEND: if (m_axis.m_tready) begin
          shift_q <= shift_q >> 8;
          if (last_byte) begin
            byte_idx  <= '0;
            remaining <= remaining - (ADDR_W+1)'(1);
            cur_addr  <= cur_addr + ADDR_W'(1);
          end else begin
            byte_idx <= byte_idx + BI_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cwc_trace_reader.sv
// Directed bench for cwc_trace_reader: scoreboard of expected stream bytes and
// RAM read addresses, filled when a dump is started and drained by a monitor.
module tb_cwc_trace_reader;
  localparam int SAMPLE_W = 67;
  localparam int ADDR_W   = 14;
  localparam int RD_LAT   = 1;
  localparam int NB       = 9;

  logic                clk;
  logic                rst_n;
  logic                dump_start;
  logic [ADDR_W-1:0]   dump_base;
  logic [ADDR_W:0]     dump_len;
  logic                dump_abort;
  logic                ram_rd_en;
  logic [ADDR_W-1:0]   ram_rd_addr;
  logic [SAMPLE_W-1:0] ram_rd_data;
  logic                busy;
  logic                done;

  cwc_trace_reader_if sif();

  cwc_trace_reader #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dump_start  (dump_start),
    .dump_base   (dump_base),
    .dump_len    (dump_len),
    .dump_abort  (dump_abort),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_axis      (sif),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rx_count = 0;
  int done_seen = 0;
  int exp_dones = 0;
  int ready_mode = 0;
  int cyc;

  logic [8:0]        exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic              stall_valid = 1'b0;
  logic [8:0]        stall_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [SAMPLE_W-1:0] sample_of(input logic [ADDR_W-1:0] a);
    logic [63:0] lo;
    lo = 64'h0123456789ABCDEF + 64'(a);
    return {3'b101, lo};
  endfunction

  // One-cycle-latency RAM holding the test pattern
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= sample_of(ram_rd_addr);

  initial begin
    sif.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0]        e;
    logic [ADDR_W-1:0] ea;
    if (!rst_n) begin
      stall_valid = 1'b0;
    end else begin
      if (sif.m_tvalid) begin
        if (stall_valid) begin
          n_checks++;
          assert ({sif.m_tlast, sif.m_tdata} === stall_val) else begin
            n_errors++;
            $error("FAIL stall_hold: observed %0h expected %0h", {sif.m_tlast, sif.m_tdata}, stall_val);
          end
        end
        stall_valid = !sif.m_tready;
        stall_val   = {sif.m_tlast, sif.m_tdata};
      end else begin
        stall_valid = 1'b0;
      end
      if (sif.m_tvalid && sif.m_tready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
        n_checks++;
        assert ({sif.m_tlast, sif.m_tdata} === e) else begin
          n_errors++;
          $error("FAIL byte %0d: observed last/data %0h expected %0h", rx_count, {sif.m_tlast, sif.m_tdata}, e);
        end
        rx_count++;
      end
      if (ram_rd_en) begin
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 'x;
        n_checks++;
        assert (ram_rd_addr === ea) else begin
          n_errors++;
          $error("FAIL rd_addr: observed %0d expected %0d", ram_rd_addr, ea);
        end
      end
      if (done) done_seen++;
    end
  end

  task automatic push_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len, input int limit);
    logic [15:0]       l16;
    logic [71:0]       v;
    logic [ADDR_W-1:0] a;
    int                n;
    l16 = 16'(len);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, l16[7:0]});
    exp_q.push_back({(len == 0), l16[15:8]});
    n = 4;
    for (int s = 0; s < int'(len); s++) begin
      if (n >= limit) break;
      a = base + ADDR_W'(s);
      addr_q.push_back(a);
      v = 72'(sample_of(a));
      for (int k = 0; k < NB; k++) begin
        if (n < limit) exp_q.push_back({(s == int'(len) - 1) && (k == NB - 1), v[8*k +: 8]});
        n++;
      end
    end
  endtask

  task automatic start_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    rx_count = 0;
    @(posedge clk);
    #1;
    dump_base  = base;
    dump_len   = len;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("tvalid_after_start", 32'(sif.m_tvalid), 32'd1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("done_pulse", 32'(done), 32'd1);
    exp_dones++;
    @(posedge clk);
    #1;
    check("done_single", 32'(done), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("addr_empty", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    dump_start  = 1'b0;
    dump_base   = '0;
    dump_len    = '0;
    dump_abort  = 1'b0;
    ram_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({sif.m_tvalid, sif.m_tlast, sif.m_tdata, busy, done, ram_rd_en, ram_rd_addr}), 32'd0);
    rst_n = 1'b1;

    push_dump(14'd0, 15'd0, 1000);
    start_dump(14'd0, 15'd0);
    wait_done(cyc);
    check("len0_cycles", 32'(cyc), 32'd4);

    push_dump(14'd0, 15'd3, 1000);
    start_dump(14'd0, 15'd3);
    wait_done(cyc);
    check("len3_cycles", 32'(cyc), 32'(4 + 3 * (1 + RD_LAT + NB)));

    push_dump(14'd16382, 15'd4, 1000);
    start_dump(14'd16382, 15'd4);
    wait_done(cyc);
    check("wrap_cycles", 32'(cyc), 32'(4 + 4 * (1 + RD_LAT + NB)));
    check("wrap_bytes", 32'(rx_count), 32'd40);

    ready_mode = 1;
    push_dump(14'd7, 15'd2, 1000);
    start_dump(14'd7, 15'd2);
    wait_done(cyc);
    check("stall_bytes", 32'(rx_count), 32'd22);
    ready_mode = 0;

    // Abort while byte 5 of sample 1 is on the bus; that byte still transfers
    push_dump(14'd0, 15'd8, 19);
    start_dump(14'd0, 15'd8);
    for (int i = 0; i < 1000 && rx_count < 18; i++) @(posedge clk);
    #1;
    dump_abort = 1'b1;
    @(posedge clk);
    #1;
    dump_abort = 1'b0;
    check("abort_tvalid", 32'(sif.m_tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(ram_rd_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_bytes", 32'(rx_count), 32'd19);
    check("abort_sb_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'(exp_dones));

    push_dump(14'd20, 15'd0, 1000);
    start_dump(14'd20, 15'd0);
    wait_done(cyc);
    check("after_abort_cycles", 32'(cyc), 32'd4);

    push_dump(14'd5, 15'd3, 1000);
    start_dump(14'd5, 15'd3);
    repeat (10) @(posedge clk);
    #1;
    dump_base  = 14'd100;
    dump_len   = 15'd7;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    wait_done(cyc);
    check("ignored_start_cycles", 32'(cyc), 32'(4 + 3 * (1 + RD_LAT + NB) - 11));

    push_dump(14'd0, 15'd8, 1000);
    start_dump(14'd0, 15'd8);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({sif.m_tvalid, sif.m_tlast, sif.m_tdata, busy, done, ram_rd_en, ram_rd_addr}), 32'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_dump(14'd9, 15'd1, 1000);
    start_dump(14'd9, 15'd1);
    wait_done(cyc);
    check("post_reset_cycles", 32'(cyc), 32'(4 + 1 + RD_LAT + NB));

    check("done_count", 32'(done_seen), 32'(exp_dones));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
